ps2_keyboard_rx: RTL and testbench

PS/2 keyboard receiver that feeds the processor's memory-mapped keyboard register (`key_reg`). It samples the external PS/2 clock/data lines, deframes 11-bit device-to-host frames, and folds E0/F0 prefixes into each key event. Completed events go into a small FIFO. The memory block reads the head entry and pops it when the CPU reads the keyboard address.

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_sync_filter.sv | 48 ++++
 rtl/ps2_keyboard_rx.sv | 171 +++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_evt_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronizes the PS/2 pins, debounces ps2_clk and produces a one-cycle
// strobe on each filtered falling edge.
module ps2_sync_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall,
   output logic data
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

   logic [1:0]    clk_sync, dat_sync;
   logic          filt, filt_d;
   logic [CW-1:0] cnt;

   // Idle bus level is high, so the pipeline resets high to avoid a false edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         filt_d   <= 1'b1;
         cnt      <= '0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         filt_d   <= filt;
         if (clk_sync[1] != filt) begin
            if (cnt == CW'(FILTER_LEN - 1)) begin
               filt <= clk_sync[1];
               cnt  <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign fall = filt_d & ~filt;
   assign data = dat_sync[1];

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes device-to-host bytes, folds E0/F0
// prefixes into key events and queues them for the CPU keyboard register.
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       key_pop,
   input  logic       err_clr,
   output logic [7:0] key_reg,
   output logic       key_break,
   output logic       key_ext,
   output logic       key_valid,
   output logic       frame_err,
   output logic       fifo_ovf
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   logic fall, data_s;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .fall     (fall),
      .data     (data_s)
   );

   ps2_state_t    state, state_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          parity_ok, parity_ok_nx;
   logic [TW-1:0] tmo_cnt;
   logic          frame_good, frame_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         parity_ok <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         parity_ok <= parity_ok_nx;
         tmo_cnt   <= (state == IDLE || fall) ? '0 : tmo_cnt + TW'(1);
      end
   end

   always_comb begin
      state_nx     = state;
      bit_cnt_nx   = bit_cnt;
      shreg_nx     = shreg;
      parity_ok_nx = parity_ok;
      frame_good   = 1'b0;
      frame_bad    = 1'b0;
      if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
         state_nx  = IDLE;
         frame_bad = 1'b1;
      end else if (fall) begin
         case (state)
            IDLE: if (!data_s) begin
               state_nx   = DATA;
               bit_cnt_nx = '0;
            end
            DATA: begin
               shreg_nx   = {data_s, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nx = PARITY;
            end
            PARITY: begin
               parity_ok_nx = ^{shreg, data_s};
               state_nx     = STOP;
            end
            STOP: begin
               state_nx = IDLE;
               if (parity_ok && data_s) frame_good = 1'b1;
               else                     frame_bad  = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Good byte is handed to the prefix/FIFO stage one cycle after the stop bit.
   logic       byte_vld;
   logic [7:0] byte_q;
   logic       ext_pend, brk_pend;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_vld <= 1'b0;
         byte_q   <= '0;
      end else begin
         byte_vld <= frame_good;
         if (frame_good) byte_q <= shreg;
      end
   end

   logic          is_prefix, push_req, do_push, do_pop, full, empty;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   key_evt_t      mem [FIFO_DEPTH];
   key_evt_t      head;

   assign is_prefix = (byte_q == PS2_EXT) || (byte_q == PS2_BRK);
   assign push_req  = byte_vld && !is_prefix;
   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = key_pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push   = push_req && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (frame_bad) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (byte_vld) begin
         if (byte_q == PS2_EXT)      ext_pend <= 1'b1;
         else if (byte_q == PS2_BRK) brk_pend <= 1'b1;
         else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= '{ext: ext_pend, brk: brk_pend, code: byte_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         frame_err <= 1'b0;
         fifo_ovf  <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
         if (frame_bad)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (push_req && !do_push) fifo_ovf <= 1'b1;
         else if (err_clr)         fifo_ovf <= 1'b0;
      end
   end

   assign head      = mem[rd_ptr];
   assign key_valid = !empty;
   assign key_reg   = empty ? 8'h00 : head.code;
   assign key_break = !empty && head.brk;
   assign key_ext   = !empty && head.ext;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx; bit period and timeout are scaled down
// by 10 relative to the real bus to keep the run short.
module tb_ps2_keyboard_rx;
   import ps2_pkg::*;

   localparam int TMO = 2000;

   logic       clk = 1'b0;
   logic       reset, ps2_clk, ps2_data, key_pop, err_clr;
   logic [7:0] key_reg;
   logic       key_break, key_ext, key_valid, frame_err, fifo_ovf;
   int         total = 0;
   int         bad = 0;

   ps2_keyboard_rx #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .key_pop   (key_pop),
      .err_clr   (err_clr),
      .key_reg   (key_reg),
      .key_break (key_break),
      .key_ext   (key_ext),
      .key_valid (key_valid),
      .frame_err (frame_err),
      .fifo_ovf  (fifo_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bit period 100 cycles: data set 25 before the fall, clock low for 50.
   // With pop_at_stop, key_pop lands in the cycle the stop-bit byte is pushed.
   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         wait_cyc(25);
         ps2_clk = 1'b0;
         if (pop_at_stop && i == 10) begin
            wait_cyc(7);
            key_pop = 1'b1;
            wait_cyc(1);
            key_pop = 1'b0;
            wait_cyc(42);
         end else begin
            wait_cyc(50);
         end
         ps2_clk = 1'b1;
         wait_cyc(25);
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] frame(input logic [7:0] code, input bit bad_par);
      logic par;
      par = ~^code ^ bad_par;
      return {1'b1, par, code, 1'b0};
   endfunction

   task automatic send(input logic [7:0] code, input bit bad_par = 0, input bit pop = 0);
      send_bits(frame(code, bad_par), 11, pop);
      wait_cyc(5);
   endtask

   task automatic do_pop();
      wait_cyc(1);
      key_pop = 1'b1;
      wait_cyc(1);
      key_pop = 1'b0;
   endtask

   task automatic chk_head(input string tag, input logic v, input logic e, input logic b,
                           input logic [7:0] code);
      chk({tag, ".valid"}, key_valid, v);
      chk({tag, ".ext"},   key_ext,   e);
      chk({tag, ".brk"},   key_break, b);
      chk({tag, ".code"},  key_reg,   code);
   endtask

   task automatic clear_err();
      wait_cyc(1);
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; key_pop = 1'b0; err_clr = 1'b0;
      wait_cyc(5);
      reset = 1'b0;
      wait_cyc(5);
      chk_head("rst", 0, 0, 0, 8'h00);
      chk("rst.ferr", frame_err, 0);
      chk("rst.ovf", fifo_ovf, 0);

      // single make code
      send(8'h1C);
      chk_head("make", 1, 0, 0, 8'h1C);
      do_pop();
      chk_head("make.pop", 0, 0, 0, 8'h00);

      // prefixes
      send(8'hF0); send(8'h1C);
      chk_head("brk", 1, 0, 1, 8'h1C);
      do_pop();
      chk("brk.one", key_valid, 0);
      send(8'hE0); send(8'hF0); send(8'h74);
      chk_head("extbrk", 1, 1, 1, 8'h74);
      do_pop();
      chk("extbrk.one", key_valid, 0);

      // parity error
      send(8'h1C, 1);
      chk("par.nopush", key_valid, 0);
      chk("par.ferr", frame_err, 1);
      clear_err();
      chk("par.clr", frame_err, 0);

      // timeout after start + 4 data bits
      send_bits(frame(8'h5A, 0), 5, 0);
      wait_cyc(TMO + 500);
      chk("tmo.ferr", frame_err, 1);
      chk("tmo.nopush", key_valid, 0);
      clear_err();
      send(8'h32);
      chk_head("tmo.next", 1, 0, 0, 8'h32);
      chk("tmo.next.ferr", frame_err, 0);
      do_pop();

      // overflow
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
      chk("ovf.set", fifo_ovf, 1);
      chk("ovf.ferr", frame_err, 0);
      chk_head("ovf.h0", 1, 0, 0, 8'h15); do_pop();
      chk_head("ovf.h1", 1, 0, 0, 8'h1D); do_pop();
      chk_head("ovf.h2", 1, 0, 0, 8'h24); do_pop();
      chk_head("ovf.h3", 1, 0, 0, 8'h2D); do_pop();
      chk("ovf.empty", key_valid, 0);
      clear_err();
      chk("ovf.clr", fifo_ovf, 0);

      // push and pop in the same cycle while full
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
      send(8'h2C, 0, 1);
      chk("pp.noovf", fifo_ovf, 0);
      chk_head("pp.h0", 1, 0, 0, 8'h1D); do_pop();
      chk_head("pp.h1", 1, 0, 0, 8'h24); do_pop();
      chk_head("pp.h2", 1, 0, 0, 8'h2D); do_pop();
      chk_head("pp.h3", 1, 0, 0, 8'h2C); do_pop();
      chk("pp.empty", key_valid, 0);

      // 2-cycle clock glitch with data low must not start a frame
      ps2_data = 1'b0;
      wait_cyc(25);
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      wait_cyc(25);
      ps2_data = 1'b1;
      wait_cyc(50);
      chk("glitch.ferr", frame_err, 0);
      chk("glitch.valid", key_valid, 0);
      send(8'h1C);
      chk_head("glitch.next", 1, 0, 0, 8'h1C);
      chk("glitch.next.ferr", frame_err, 0);

      // reset mid-frame with an entry queued and E0 pending
      send(8'hE0);
      send_bits(frame(8'h1C, 0), 5, 0);
      reset = 1'b1;
      wait_cyc(3);
      reset = 1'b0;
      wait_cyc(2);
      chk_head("midrst", 0, 0, 0, 8'h00);
      chk("midrst.ferr", frame_err, 0);
      chk("midrst.ovf", fifo_ovf, 0);
      wait_cyc(50);
      send(8'h1C);
      chk_head("midrst.next", 1, 0, 0, 8'h1C);
      chk("midrst.next.ferr", frame_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
